proc3_param: RTL and testbench

- Parametrised multicycle successor to the team's 16-bit processor.
- Eight architectural registers: r0–r6 are general purpose; r7 aliases the PC.
- Adds N/Z/C flags, a full conditional-branch set, branch-and-link, and cmp.
- Replaces fixed memory wait states with a req/ack handshake to one unified instruction/data memory.
- 16-bit instruction encoding is unchanged (III=IR[15:13], Imm=IR[12], rX=IR[11:9], rY=IR[2:0]); data width is generalised.

---
 rtl/proc3_param_if.sv | 31 +++
 rtl/proc3_param.sv | 199 +++++++++++++++++++
 tb/tb_proc3_param.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc3_param_if.sv
// Unified instruction/data memory bus for proc3_param: req/ack handshake,
// one transfer in flight, read data valid in the ack cycle.
interface proc3_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/proc3_param.sv
// Parametrised multicycle processor: r0-r6 general purpose, r7 is the PC,
// N/Z/C flags, one unified memory behind a req/ack handshake.
module proc3_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  output logic              Done,
  proc3_param_if.master     mem,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        flags
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("proc3_param: DATA_W must be >= 16");
  end

  localparam int unsigned ExtW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvt = 3'b001;  // also branches when IR[12]=0
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpLd  = 3'b100;
  localparam logic [2:0] OpSt  = 3'b101;
  localparam logic [2:0] OpAnd = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [7];
  logic [DATA_W-1:0] regs_d [7];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [2:0]        flags_q, flags_d;

  logic [DATA_W-1:0] rf_view [8];
  logic [2:0]        op, rx, ry;
  logic              imm_sel;
  logic [DATA_W-1:0] imm, rx_val, ry_val, operand, mvt_val, and_res;
  logic [DATA_W:0]   add_res, sub_res;
  logic              taken;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] addr_src;
  logic [ExtW-1:0]   addr_ext;

  always_comb begin
    for (int i = 0; i < 7; i++) rf_view[i] = regs_q[i];
    rf_view[7] = pc_q;
  end

  assign op      = ir_q[15:13];
  assign imm_sel = ir_q[12];
  assign rx      = ir_q[11:9];
  assign ry      = ir_q[2:0];
  assign imm     = DATA_W'($signed(ir_q[8:0]));
  assign mvt_val = DATA_W'({ir_q[7:0], 8'h00});
  assign rx_val  = rf_view[rx];
  assign ry_val  = rf_view[ry];
  assign operand = imm_sel ? imm : ry_val;
  assign add_res = {1'b0, rx_val} + {1'b0, operand};
  assign sub_res = {1'b0, rx_val} - {1'b0, operand};
  assign and_res = rx_val & operand;

  assign dbg_data = rf_view[dbg_sel];
  assign flags    = flags_q;

  // Branch condition lives in the rX field; flags_q is {N,Z,C}.
  always_comb begin
    taken = 1'b0;
    unique case (rx)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flags_q[1];
      3'b010:  taken = ~flags_q[1];
      3'b011:  taken = ~flags_q[0];
      3'b100:  taken = flags_q[0];
      3'b101:  taken = ~flags_q[2];
      3'b110:  taken = flags_q[2];
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    regs_d        = regs_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    flags_d       = flags_q;
    Done          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    addr_src      = '0;
    wr_en         = 1'b0;
    wr_val        = '0;

    unique case (state_q)
      StIdle: begin
        if (Run) state_d = StFetch;
      end
      StFetch: begin
        mem.mem_req = 1'b1;
        addr_src    = pc_q;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata[15:0];
          pc_d    = pc_q + DATA_W'(1);
          state_d = StExec;
        end
      end
      StExec: begin
        if (op == OpLd || op == OpSt) begin
          state_d = StMem;
        end else begin
          Done    = 1'b1;
          state_d = Run ? StFetch : StIdle;
        end
        unique case (op)
          OpMv: begin
            wr_en  = 1'b1;
            wr_val = operand;
          end
          OpMvt: begin
            if (imm_sel) begin
              wr_en  = 1'b1;
              wr_val = mvt_val;
            end else if (taken) begin
              // bl links the already-incremented PC into r6
              if (rx == 3'b111) regs_d[6] = pc_q;
              pc_d = pc_q + imm;
            end
          end
          OpAdd: begin
            wr_en   = 1'b1;
            wr_val  = add_res[DATA_W-1:0];
            flags_d = {add_res[DATA_W-1], add_res[DATA_W-1:0] == '0, add_res[DATA_W]};
          end
          OpSub, OpCmp: begin
            wr_en   = (op == OpSub);
            wr_val  = sub_res[DATA_W-1:0];
            flags_d = {sub_res[DATA_W-1], sub_res[DATA_W-1:0] == '0, ~sub_res[DATA_W]};
          end
          OpAnd: begin
            wr_en   = 1'b1;
            wr_val  = and_res;
            flags_d = {and_res[DATA_W-1], and_res == '0, flags_q[0]};
          end
          OpLd, OpSt: ;
          default: ;
        endcase
      end
      StMem: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = (op == OpSt);
        mem.mem_wdata = rx_val;
        addr_src      = ry_val;
        if (mem.mem_ack) begin
          wr_en   = (op == OpLd);
          wr_val  = mem.mem_rdata;
          Done    = 1'b1;
          state_d = Run ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // r7 writes land in the PC, which makes mv r7,rY a jump
    for (int i = 0; i < 7; i++) begin
      if (wr_en && rx == 3'(i)) regs_d[i] = wr_val;
    end
    if (wr_en && rx == 3'd7) pc_d = wr_val;
  end

  assign addr_ext     = ExtW'(addr_src);
  assign mem.mem_addr = addr_ext[ADDR_W-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      for (int i = 0; i < 7; i++) regs_q[i] <= '0;
      pc_q    <= DATA_W'(RESET_PC);
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_proc3_param.sv
// Scoreboarded bench for proc3_param: expected bus transfers are queued per
// program and popped on every acked transfer; registers checked via dbg port.
module tb_proc3_param;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  logic          Clock   = 1'b0;
  logic          Resetn  = 1'b0;
  logic          Run     = 1'b0;
  logic          Done;
  logic [2:0]    dbg_sel = 3'd0;
  logic [DW-1:0] dbg_data;
  logic [2:0]    flags;

  proc3_param_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  proc3_param #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Run      (Run),
    .Done     (Done),
    .mem      (mem_if.master),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .flags    (flags)
  );

  always #5 Clock = ~Clock;

  // Memory model: program below 0x40, data at/above; separate wait counts.
  logic [15:0]   prog [256];
  logic [DW-1:0] dmem [256];
  int            fetch_wait = 0;
  int            data_wait  = 0;
  int            wait_cnt   = 0;
  int            cyc        = 0;
  logic [15:0]   junk       = 16'h1B55;
  logic          is_data;

  assign is_data        = (mem_if.mem_addr >= 16'h0040);
  assign mem_if.mem_ack = mem_if.mem_req && (wait_cnt >= (is_data ? data_wait : fetch_wait));
  assign mem_if.mem_rdata = !mem_if.mem_ack ? DW'(junk) :
                            is_data ? dmem[mem_if.mem_addr[7:0]] :
                                      DW'(prog[mem_if.mem_addr[7:0]]);

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (mem_if.mem_req && !mem_if.mem_ack) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
    if (mem_if.mem_req && mem_if.mem_ack && mem_if.mem_we && is_data)
      dmem[mem_if.mem_addr[7:0]] <= mem_if.mem_wdata;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  xfer_t exp_q [$];
  int    done_rel [$];
  int    req_cycles;
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic i,
                                      input logic [2:0] rx, input logic [8:0] low);
    return {op, i, rx, low};
  endfunction

  task automatic expect_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xfer_t e;
    e.we = we; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [DW-1:0] val);
    dbg_sel = sel;
    #1;
    val = dbg_data;
  endtask

  task automatic prep();
    Resetn = 1'b0;
    Run    = 1'b0;
    fetch_wait = 0;
    data_wait  = 0;
    junk       = 16'h1B55;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  // Runs until n instructions retire, dropping Run in the last Done cycle.
  task automatic run_prog(input int n, input int budget);
    int            seen  = 0;
    int            first = -1;
    logic          prev_req = 1'b0, prev_ack = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    xfer_t         e;
    done_rel.delete();
    req_cycles = 0;
    Run = 1'b1;
    for (int t = 0; t < budget && seen < n; t++) begin
      @(negedge Clock);
      if (mem_if.mem_req) begin
        req_cycles++;
        if (first < 0) first = cyc;
        if (prev_req && !prev_ack) begin
          vectors++;
          if (mem_if.mem_addr !== prev_addr) begin
            miscompares++;
            $display("FAIL addr_stable: got %h required %h", mem_if.mem_addr, prev_addr);
          end
        end
      end
      if (mem_if.mem_req && mem_if.mem_ack) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_xfer: got we=%b addr=%h", mem_if.mem_we, mem_if.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_if.mem_we !== e.we || mem_if.mem_addr !== e.addr ||
              (e.we && mem_if.mem_wdata !== e.wdata)) begin
            miscompares++;
            $display("FAIL xfer: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, e.we, e.addr, e.wdata);
          end
        end
      end
      prev_req  = mem_if.mem_req;
      prev_ack  = mem_if.mem_ack;
      prev_addr = mem_if.mem_addr;
      if (Done === 1'b1) begin
        done_rel.push_back(cyc - first + 1);
        seen++;
        if (seen == n) Run = 1'b0;
      end
    end
    vectors++;
    if (seen != n) begin
      miscompares++;
      $display("FAIL retire_timeout: got %0d Done pulses required %0d", seen, n);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_xfers: got %0d left required 0", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    prep();
    vectors += 4;
    if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b required 0", Done); end
    if (mem_if.mem_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_req: got %b required 0", mem_if.mem_req);
    end
    if (mem_if.mem_we !== 1'b0) begin
      miscompares++; $display("FAIL rst_we: got %b required 0", mem_if.mem_we);
    end
    if (flags !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b required 000", flags); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      vectors++;
      if (v !== '0) begin miscompares++; $display("FAIL rst_r%0d: got %h required 0000", i, v); end
    end
  endtask

  task automatic test_add_flags();
    logic [DW-1:0] v;
    prep();
    prog[0] = enc(3'b000, 1'b1, 3'd0, 9'd5);
    prog[1] = enc(3'b010, 1'b1, 3'd0, 9'h1FA);
    expect_xfer(1'b0, 16'h0000, '0);
    expect_xfer(1'b0, 16'h0001, '0);
    run_prog(2, 50);
    vectors++;
    if (done_rel.size() != 2) begin
      miscompares++; $display("FAIL add_done_count: got %0d required 2", done_rel.size());
    end else begin
      vectors++;
      if (done_rel[0] != 2 || done_rel[1] != 4) begin
        miscompares++;
        $display("FAIL add_done_cycles: got %0d,%0d required 2,4", done_rel[0], done_rel[1]);
      end
    end
    read_reg(3'd0, v);
    vectors += 2;
    if (v !== 16'hFFFF) begin miscompares++; $display("FAIL add_r0: got %h required ffff", v); end
    if (flags !== 3'b100) begin miscompares++; $display("FAIL add_flags: got %b required 100", flags); end
  endtask

  task automatic test_fetch_wait();
    logic [DW-1:0] v;
    prep();
    fetch_wait = 3;
    junk    = enc(3'b000, 1'b1, 3'd1, 9'd1);
    prog[0] = enc(3'b000, 1'b1, 3'd1, 9'd7);
    expect_xfer(1'b0, 16'h0000, '0);
    run_prog(1, 50);
    vectors += 2;
    if (req_cycles != 4) begin
      miscompares++; $display("FAIL wait_req_cycles: got %0d required 4", req_cycles);
    end
    if (done_rel.size() != 1 || done_rel[0] != 5) begin
      miscompares++; $display("FAIL wait_done: got %0d pulses required 1 at cycle 5", done_rel.size());
    end
    read_reg(3'd1, v);
    vectors++;
    if (v !== 16'h0007) begin miscompares++; $display("FAIL wait_ir_r1: got %h required 0007", v); end
  endtask

  task automatic test_cmp_branch();
    logic [DW-1:0] v;
    prep();
    prog[0] = enc(3'b000, 1'b1, 3'd1, 9'd3);
    prog[1] = enc(3'b111, 1'b1, 3'd1, 9'd3);
    prog[2] = enc(3'b001, 1'b0, 3'b001, 9'd2);
    prog[3] = enc(3'b000, 1'b1, 3'd1, 9'd9);
    prog[5] = enc(3'b000, 1'b1, 3'd2, 9'd9);
    expect_xfer(1'b0, 16'h0000, '0);
    expect_xfer(1'b0, 16'h0001, '0);
    expect_xfer(1'b0, 16'h0002, '0);
    expect_xfer(1'b0, 16'h0005, '0);
    run_prog(4, 80);
    vectors++;
    if (flags !== 3'b011) begin miscompares++; $display("FAIL cmp_flags: got %b required 011", flags); end
    read_reg(3'd1, v);
    vectors++;
    if (v !== 16'h0003) begin miscompares++; $display("FAIL cmp_r1: got %h required 0003", v); end
    read_reg(3'd2, v);
    vectors++;
    if (v !== 16'h0009) begin miscompares++; $display("FAIL beq_r2: got %h required 0009", v); end
    read_reg(3'd7, v);
    vectors++;
    if (v !== 16'h0006) begin miscompares++; $display("FAIL beq_pc: got %h required 0006", v); end
  endtask

  task automatic test_bl();
    logic [DW-1:0] v;
    prep();
    prog[0]  = enc(3'b000, 1'b1, 3'd7, 9'h010);
    prog[16] = enc(3'b001, 1'b0, 3'b111, 9'h1FC);
    prog[13] = enc(3'b000, 1'b1, 3'd0, 9'd1);
    expect_xfer(1'b0, 16'h0000, '0);
    expect_xfer(1'b0, 16'h0010, '0);
    expect_xfer(1'b0, 16'h000D, '0);
    run_prog(3, 80);
    vectors++;
    if (done_rel.size() != 3 || done_rel[2] != 6) begin
      miscompares++; $display("FAIL bl_no_bubble: got %0d pulses required 3 ending at cycle 6", done_rel.size());
    end
    read_reg(3'd6, v);
    vectors++;
    if (v !== 16'h0011) begin miscompares++; $display("FAIL bl_r6: got %h required 0011", v); end
    read_reg(3'd7, v);
    vectors++;
    if (v !== 16'h000E) begin miscompares++; $display("FAIL bl_pc: got %h required 000e", v); end
    read_reg(3'd0, v);
    vectors++;
    if (v !== 16'h0001) begin miscompares++; $display("FAIL bl_r0: got %h required 0001", v); end
  endtask

  task automatic test_ld_st();
    logic [DW-1:0] v;
    prep();
    prog[0] = enc(3'b001, 1'b1, 3'd2, 9'h0AB);
    prog[1] = enc(3'b010, 1'b1, 3'd2, 9'h0CD);
    prog[2] = enc(3'b000, 1'b1, 3'd3, 9'h040);
    prog[3] = enc(3'b101, 1'b0, 3'd2, 9'd3);
    prog[4] = enc(3'b100, 1'b0, 3'd4, 9'd3);
    for (int i = 0; i < 4; i++) expect_xfer(1'b0, AW'(i), '0);
    expect_xfer(1'b1, 16'h0040, 16'hABCD);
    expect_xfer(1'b0, 16'h0004, '0);
    expect_xfer(1'b0, 16'h0040, '0);
    run_prog(5, 100);
    vectors++;
    if (done_rel.size() != 5) begin
      miscompares++; $display("FAIL ldst_done_count: got %0d required 5", done_rel.size());
    end else begin
      vectors++;
      if (done_rel[3] - done_rel[2] != 3 || done_rel[4] - done_rel[3] != 3) begin
        miscompares++;
        $display("FAIL ldst_latency: got %0d,%0d required 3,3",
                 done_rel[3] - done_rel[2], done_rel[4] - done_rel[3]);
      end
    end
    vectors += 2;
    if (dmem[8'h40] !== 16'hABCD) begin
      miscompares++; $display("FAIL st_mem: got %h required abcd", dmem[8'h40]);
    end
    if (flags !== 3'b100) begin miscompares++; $display("FAIL ldst_flags: got %b required 100", flags); end
    read_reg(3'd4, v);
    vectors++;
    if (v !== 16'hABCD) begin miscompares++; $display("FAIL ld_r4: got %h required abcd", v); end
  endtask

  task automatic test_reset_mid_mem();
    logic [DW-1:0] v;
    logic          found = 1'b0;
    prep();
    prog[0] = enc(3'b000, 1'b1, 3'd3, 9'h040);
    prog[1] = enc(3'b100, 1'b0, 3'd0, 9'd3);
    expect_xfer(1'b0, 16'h0000, '0);
    run_prog(1, 50);
    data_wait = 1000;
    Run = 1'b1;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge Clock);
      if (mem_if.mem_req && mem_if.mem_addr == 16'h0040) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL mid_mem_reach: got no data request required one"); end
    #2;
    Resetn = 1'b0;
    #1;
    vectors += 3;
    if (mem_if.mem_req !== 1'b0) begin
      miscompares++; $display("FAIL async_req_drop: got %b required 0", mem_if.mem_req);
    end
    if (mem_if.mem_we !== 1'b0) begin
      miscompares++; $display("FAIL async_we: got %b required 0", mem_if.mem_we);
    end
    if (Done !== 1'b0) begin miscompares++; $display("FAIL async_done: got %b required 0", Done); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      vectors++;
      if (v !== '0) begin miscompares++; $display("FAIL mid_rst_r%0d: got %h required 0000", i, v); end
    end
    @(negedge Clock);
    data_wait = 0;
    Resetn = 1'b1;
    expect_xfer(1'b0, 16'h0000, '0);
    run_prog(1, 50);
    vectors++;
    if (done_rel.size() != 1 || done_rel[0] != 2) begin
      miscompares++; $display("FAIL restart_done: got %0d pulses required 1 at cycle 2", done_rel.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_fetch_wait();
    test_cmp_branch();
    test_bl();
    test_ld_st();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
